axis_video_pattern_gen: RTL and testbench
=========================================

# axis_video_pattern_gen

Parametrised AXI4-Stream video source that generates frames of configurable geometry and pixel format, with selectable pattern modes and pseudo-random valid-gap injection. It is the synthesizable successor of the Keystone bench's fixed 1920x1080 stimulus. It drives the Keystone input (or any video-stream consumer) in simulation and on hardware for in-system self-test. Output packing matches the Keystone pixel word: channel k occupies slot bits [SLOT_WIDTH*k+SLOT_WIDTH-1 : SLOT_WIDTH*k], with the component at offset COMP_OFFSET. Channel order is 0=G, 1=B, 2=R.

## Interface
- DATA_WIDTH, 64, tdata width; must be ≥ CHANNELS*SLOT_WIDTH; unused bits are 0
- CHANNELS, 3, colour channels
- SLOT_WIDTH, 10, bits per channel slot
- COMP_WIDTH, 8, component bits; COMP_OFFSET+COMP_WIDTH ≤ SLOT_WIDTH; CHANNELS*COMP_WIDTH ≤ 32
- COMP_OFFSET, 2, LSB position of component within slot
- H_ACTIVE, 1920, pixels per line; must be a multiple of 8
- V_ACTIVE, 1080, lines per frame
- V_BLANK, 0, idle cycles between frames
- LFSR_SEED, 32'hACE1_2468, reset value of both LFSRs; must be nonzero
---
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- aclken  in  1  clock enable; when low, all state freezes
- start  in  1  begin generation; sampled in IDLE only
- stop  in  1  finish current frame, then go to IDLE; sticky until honoured
- num_frames  in  16  frame count; 0 = infinite
- mode  in  2  pattern: 0 ramp, 1 colour bars, 2 constant, 3 random
- const_val  in  CHANNELS*COMP_WIDTH  constant-mode components, channel 0 in the LSBs
- gap_en  in  1  enable valid-gap injection
- gap_mask  in  16  gap when (gap_lfsr & gap_mask) == 0
- m_axis_video_tdata  out  DATA_WIDTH  pixel
- m_axis_video_tvalid  out  1  beat valid
- m_axis_video_tready  in  1  downstream ready
- m_axis_video_tuser  out  1  start of frame
- m_axis_video_tlast  out  1  end of line
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the final frame completes
- frame_count  out  16  frames completed since start

## Operation
- FSM states: IDLE, RUN, BLANK.
  - IDLE→RUN on start. This clears frame_count and x/y, and latches num_frames.
  - In RUN, a beat is accepted when tvalid & tready. x increments per accepted beat; it wraps at H_ACTIVE-1 and y increments on the wrap.
  - After the last pixel (x=H_ACTIVE-1, y=V_ACTIVE-1) is accepted, frame_count increments. Then:
    - if stop is pending, or num_frames≠0 and frame_count+1==num_frames: go to IDLE and pulse done;
    - else if V_BLANK==0: stay in RUN, next frame begins;
    - else: go to BLANK for exactly V_BLANK cycles, then RUN.
- mode and const_val are latched when each frame's first beat is formed. Changes mid-frame are ignored.
- Patterns, with component values truncated to COMP_WIDTH:
  - ramp: ch0 = x+y, ch1 = x, ch2 = y; channels ≥3 use x+k.
  - bars: bar = x / (H_ACTIVE/8); channel k = all-ones if bar bit (k mod 3) is set, else 0.
  - constant: channel k = const_val slice k.
  - random: channel k = data_lfsr[COMP_WIDTH*k +: COMP_WIDTH]. data_lfsr is a 32-bit Galois LFSR (taps 32,22,2,1). It advances once per accepted beat and is reseeded to LFSR_SEED at every start.
- Gap injection: a 16-bit gap_lfsr free-runs on every enabled cycle. When no beat is pending and gap_en=1 with a gap condition, tvalid stays low that cycle. A pending beat (tvalid=1, not yet accepted) is never withdrawn.
- tuser=1 only on x=0,y=0. tlast=1 only on x=H_ACTIVE-1.

## Timing
- All outputs are registered.
- Reset values: tvalid 0, tdata 0, tuser 0, tlast 0, busy 0, done 0, frame_count 0, state IDLE, x=y=0, both LFSRs = LFSR_SEED.
- start in cycle n → busy=1 and first beat tvalid=1 in cycle n+1 (absent a gap).
- With tready=1 and gap_en=0, one beat per cycle, with no bubble at line or frame boundaries when V_BLANK=0.
- While tvalid=1 & tready=0, tdata/tuser/tlast are stable.
- done and busy=0 appear in the cycle after the final accept.
- start while busy is ignored.
- stop together with start in IDLE: start wins, stop becomes pending.
- aresetn low mid-frame clears immediately (tvalid may drop). No partial frame resumes.

## Test plan
- H_ACTIVE=8, V_ACTIVE=2, mode 0, num_frames=1, tready=1.
  → 16 consecutive beats; tuser on beat 0 only; tlast on beats 7 and 15; ch0 = 0..7 then 1..8; done pulses 1 cycle after beat 15; frame_count=1.
- Same setup, tready low for 5 cycles while beat 2 is presented.
  → tvalid stays 1; tdata=ramp(x=2) held stable; no beat lost or duplicated.
- mode 1, H_ACTIVE=16.
  → bar width 2; bar 3 gives ch0=ch1=0xFF, ch2=0; bar 7 gives all 0xFF.
- gap_en=1, gap_mask=0x0003, tready toggling randomly.
  → no pending beat is ever withdrawn; exactly H_ACTIVE*V_ACTIVE beats per frame; random-mode data matches a reference LFSR stepped once per accept.
- num_frames=0, V_BLANK=3; stop asserted mid-frame 2.
  → frame 2 completes; 3 idle cycles between frames 1 and 2; done pulses once; frame_count=2.
- aresetn low mid-line; separately, aclken low for 4 cycles.
  → reset zeroes all outputs asynchronously and restart begins at tuser; aclken low freezes tdata, x and the LFSRs.

Source files
------------

// File: rtl/axis_video_pattern_gen_if.sv
// axis_video_pattern_gen_if: AXI4-Stream video bus between a pixel source and a sink.
// Signals: tdata (pixel word), tvalid/tready (handshake), tuser (start of frame), tlast (end of line).
// Modports: master drives tdata/tvalid/tuser/tlast and samples tready; slave is the mirror image.
interface axis_video_pattern_gen_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;
    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen: AXI4-Stream video source with selectable patterns and valid-gap injection.
// Ports: aclk/aresetn/aclken clocking; start/stop/num_frames control a run of frames; mode/const_val
// select the pattern; gap_en/gap_mask throttle tvalid; m_axis_video carries pixels (tuser = first pixel
// of a frame, tlast = last pixel of a line); busy/done/frame_count report progress.
module axis_video_pattern_gen #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          CHANNELS    = 3,
    parameter int          SLOT_WIDTH  = 10,
    parameter int          COMP_WIDTH  = 8,
    parameter int          COMP_OFFSET = 2,
    parameter int          H_ACTIVE    = 1920,
    parameter int          V_ACTIVE    = 1080,
    parameter int          V_BLANK     = 0,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           aclken,
    input  logic                           start,
    input  logic                           stop,
    input  logic [15:0]                    num_frames,
    input  logic [1:0]                     mode,
    input  logic [CHANNELS*COMP_WIDTH-1:0] const_val,
    input  logic                           gap_en,
    input  logic [15:0]                    gap_mask,
    axis_video_pattern_gen_if.master       m_axis_video,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    frame_count
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
    localparam int BW = V_BLANK > 1 ? $clog2(V_BLANK) : 1;
    localparam int CW = CHANNELS * COMP_WIDTH;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, BLANK = 2'd2;

    logic [1:0]            state_q, state_d, mode_q, mode_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [BW-1:0]         blank_q, blank_d;
    logic [31:0]           data_lfsr_q, data_lfsr_d;
    logic [15:0]           gap_lfsr_q, gap_lfsr_d, nf_q, nf_d, fc_q, fc_d;
    logic [CW-1:0]         const_q, const_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d, pix;
    logic                  stop_q, stop_d, tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  accept, last_x, last_y, frame_end, form, emit, first;
    logic [2:0]            bar;
    logic [COMP_WIDTH-1:0] comp;

    always_comb begin
        accept      = tvalid_q & m_axis_video.tready;
        last_x      = x_q == XW'(H_ACTIVE - 1);
        last_y      = y_q == YW'(V_ACTIVE - 1);
        frame_end   = accept & last_x & last_y;
        state_d     = state_q;
        x_d         = accept ? (last_x ? '0 : x_q + XW'(1)) : x_q;
        y_d         = accept & last_x ? (last_y ? '0 : y_q + YW'(1)) : y_q;
        blank_d     = blank_q;
        nf_d        = nf_q;
        fc_d        = frame_end ? fc_q + 16'd1 : fc_q;
        stop_d      = stop_q | stop;
        done_d      = 1'b0;
        data_lfsr_d = accept ? (data_lfsr_q >> 1) ^ (data_lfsr_q[0] ? 32'h8020_0003 : 32'h0) : data_lfsr_q;
        gap_lfsr_d  = (gap_lfsr_q >> 1) ^ (gap_lfsr_q[0] ? 16'hB400 : 16'h0);
        if (state_q == IDLE) begin
            // a stop arriving with start is kept so the run ends after one frame
            stop_d = start & stop;
            if (start) begin
                state_d     = RUN;
                x_d         = '0;
                y_d         = '0;
                fc_d        = '0;
                nf_d        = num_frames;
                data_lfsr_d = LFSR_SEED;
            end
        end else if (state_q == BLANK) begin
            state_d = blank_q == '0 ? RUN : BLANK;
            blank_d = blank_q - BW'(1);
        end else if (frame_end) begin
            if (stop_q | stop || (nf_q != 16'd0 && fc_q + 16'd1 == nf_q)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                stop_d  = 1'b0;
            end else if (V_BLANK != 0) begin
                state_d = BLANK;
                blank_d = BW'(V_BLANK - 1);
            end
        end
        // a new beat is formed whenever the output register is free in RUN; the gap only
        // suppresses forming, it never withdraws a beat already presented
        form    = state_d == RUN && !(tvalid_q && !accept);
        emit    = form & ~(gap_en & ((gap_lfsr_q & gap_mask) == 16'd0));
        first   = x_d == '0 && y_d == '0;
        mode_d  = emit & first ? mode : mode_q;
        const_d = emit & first ? const_val : const_q;
        bar     = 3'(32'(x_d) / (H_ACTIVE / 8));
        pix     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            comp = mode_d == 2'd0 ? (k == 0 ? COMP_WIDTH'(32'(x_d) + 32'(y_d)) :
                                     k == 1 ? COMP_WIDTH'(x_d) :
                                     k == 2 ? COMP_WIDTH'(y_d) : COMP_WIDTH'(32'(x_d) + 32'(k)))
                 : mode_d == 2'd1 ? {COMP_WIDTH{bar[2'(k % 3)]}}
                 : mode_d == 2'd2 ? const_d[COMP_WIDTH*k +: COMP_WIDTH]
                 : data_lfsr_d[COMP_WIDTH*k +: COMP_WIDTH];
            pix[SLOT_WIDTH*k+COMP_OFFSET +: COMP_WIDTH] = comp;
        end
        tvalid_d = emit | (tvalid_q & ~accept);
        tdata_d  = emit ? pix : tdata_q;
        tuser_d  = emit ? first : tuser_q;
        tlast_d  = emit ? x_d == XW'(H_ACTIVE - 1) : tlast_q;
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            blank_q     <= '0;
            data_lfsr_q <= LFSR_SEED;
            gap_lfsr_q  <= LFSR_SEED[15:0];
            nf_q        <= '0;
            fc_q        <= '0;
            mode_q      <= '0;
            const_q     <= '0;
            stop_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (aclken) begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            blank_q     <= blank_d;
            data_lfsr_q <= data_lfsr_d;
            gap_lfsr_q  <= gap_lfsr_d;
            nf_q        <= nf_d;
            fc_q        <= fc_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
            stop_q      <= stop_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m_axis_video.tdata  = tdata_q;
    assign m_axis_video.tvalid = tvalid_q;
    assign m_axis_video.tuser  = tuser_q;
    assign m_axis_video.tlast  = tlast_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign frame_count         = fc_q;
endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// tb_axis_video_pattern_gen: directed and randomized checks of the pattern generator against a reference model.
module tb_axis_video_pattern_gen;
    localparam int          H    = 16;
    localparam int          V    = 2;
    localparam int          VB   = 3;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        aclk = 0, aresetn = 0, aclken = 1, start = 0, stop = 0, gap_en = 0;
    logic [15:0] num_frames = 0, gap_mask = 0;
    logic [1:0]  mode = 0;
    logic [23:0] const_val = 0;
    logic        busy, done;
    logic [15:0] frame_count;

    axis_video_pattern_gen_if #(.DATA_WIDTH(64)) vif ();

    axis_video_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .V_BLANK(VB), .LFSR_SEED(SEED)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .start(start), .stop(stop),
        .num_frames(num_frames), .mode(mode), .const_val(const_val), .gap_en(gap_en),
        .gap_mask(gap_mask), .m_axis_video(vif), .busy(busy), .done(done), .frame_count(frame_count)
    );

    always #5 aclk = ~aclk;

    int          n_assert = 0, n_fail = 0, idx = 0, frames = 0, n_done = 0;
    logic [31:0] ref_lfsr = SEED;
    logic [1:0]  fr_mode = 0;
    logic [23:0] fr_const = 0;
    bit          pend = 0;
    logic [63:0] pend_data = 0;
    logic [1:0]  pend_ul = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s = {1'b0, s[31:1]};
        if (fb) begin
            s[31] = 1'b1;
            s[21] = ~s[21];
            s[1]  = ~s[1];
            s[0]  = ~s[0];
        end
        return s;
    endfunction

    function automatic logic [63:0] ref_pix(input int x, input int y, input logic [1:0] m,
                                            input logic [23:0] cv, input logic [31:0] lf);
        logic [7:0]  c [3];
        logic [63:0] w;
        int          b;
        b = x / (H / 8);
        for (int k = 0; k < 3; k++)
            case (m)
                2'd0:    c[k] = 8'(k == 0 ? x + y : k == 1 ? x : y);
                2'd1:    c[k] = ((b >> k) & 1) != 0 ? 8'hFF : 8'h00;
                2'd2:    c[k] = 8'(cv >> (8 * k));
                default: c[k] = 8'(lf >> (8 * k));
            endcase
        w = '0;
        for (int k = 0; k < 3; k++) w = w | (64'(c[k]) << (10 * k + 2));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: monitor the stream mid-cycle, then return just after the rising edge
    task automatic tick();
        @(negedge aclk);
        if (aresetn && aclken) begin
            if (pend) begin
                chk("hold_valid", 64'(vif.tvalid), 64'd1);
                chk("hold_data", vif.tdata, pend_data);
                chk("hold_user_last", 64'({vif.tuser, vif.tlast}), 64'(pend_ul));
            end
            if (!busy && start) begin
                ref_lfsr = SEED;
                idx = 0;
            end
            if (vif.tvalid && vif.tuser && !pend) begin
                fr_mode = mode;
                fr_const = const_val;
            end
            if (vif.tvalid && vif.tready) begin
                chk("beat_data", vif.tdata, ref_pix(idx % H, idx / H, fr_mode, fr_const, ref_lfsr));
                chk("beat_user", 64'(vif.tuser), 64'(idx == 0));
                chk("beat_last", 64'(vif.tlast), 64'(idx % H == H - 1));
                ref_lfsr = lfsr_next(ref_lfsr);
                idx++;
                if (idx == H * V) begin
                    idx = 0;
                    frames++;
                end
            end
            pend = vif.tvalid && !vif.tready;
            pend_data = vif.tdata;
            pend_ul = {vif.tuser, vif.tlast};
            if (done) n_done++;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (!(vif.tvalid && idx == target) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idx_reached", 64'(vif.tvalid && idx == target), 64'd1);
    endtask

    task automatic run_to_done(input int budget, input bit rnd);
        int n = 0;
        while (!done && n < budget) begin
            if (rnd) vif.tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        vif.tready = 1;
        chk("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int          n, f0, d0;
        logic [63:0] held;
        vif.tready = 1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 64'(vif.tvalid), 64'd0);
        chk("rst_tdata", vif.tdata, 64'd0);
        chk("rst_tuser_tlast", 64'({vif.tuser, vif.tlast}), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        aresetn = 1;
        tick();

        // ramp, single frame, continuous beats
        mode = 0; num_frames = 1;
        do_start();
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_tvalid", 64'(vif.tvalid), 64'd1);
        chk("start_tuser", 64'(vif.tuser), 64'd1);
        for (int i = 0; i < H * V; i++) begin
            chk("no_bubble", 64'(vif.tvalid), 64'd1);
            tick();
        end
        chk("ramp_done", 64'(done), 64'd1);
        chk("ramp_busy_low", 64'(busy), 64'd0);
        chk("ramp_frame_count", 64'(frame_count), 64'd1);
        chk("ramp_frames_seen", 64'(frames), 64'd1);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);

        // backpressure on beat 2, plus a start while busy
        do_start();
        wait_idx(2);
        held = vif.tdata;
        chk("bp_beat2_ramp", held, ref_pix(2, 0, 2'd0, 24'd0, 32'd0));
        vif.tready = 0;
        repeat (5) begin
            tick();
            chk("bp_tdata_stable", vif.tdata, held);
        end
        vif.tready = 1;
        wait_idx(10);
        do_start();
        run_to_done(100, 0);
        chk("bp_frame_count", 64'(frame_count), 64'd1);
        chk("bp_frames_seen", 64'(frames), 64'd2);

        // colour bars
        mode = 1;
        do_start();
        wait_idx(6);
        chk("bar3", vif.tdata, 64'h0000_0000_000F_F3FC);
        wait_idx(14);
        chk("bar7", vif.tdata, 64'h0000_0000_3FCF_F3FC);
        run_to_done(100, 0);

        // constant mode; mid-frame changes of mode/const_val are ignored
        mode = 2; const_val = 24'($urandom);
        do_start();
        wait_idx(10);
        mode = 0; const_val = 24'($urandom);
        run_to_done(100, 0);

        // random data with gap injection and random tready over two frames
        mode = 3; gap_en = 1; gap_mask = 16'h0003; num_frames = 2;
        f0 = frames;
        do_start();
        run_to_done(3000, 1);
        chk("gap_frame_count", 64'(frame_count), 64'd2);
        chk("gap_frames_seen", 64'(frames - f0), 64'd2);
        gap_en = 0;

        // infinite run: vertical blank then stop during frame 2
        mode = 0; num_frames = 0;
        f0 = frames;
        do_start();
        n = 0;
        while (frames < f0 + 1 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (!vif.tvalid && n < 20) begin
            chk("blank_busy", 64'(busy), 64'd1);
            tick();
            n++;
        end
        chk("blank_cycles", 64'(n), 64'(VB));
        chk("frame2_tuser", 64'(vif.tuser), 64'd1);
        wait_idx(10);
        d0 = n_done;
        stop = 1;
        tick();
        stop = 0;
        run_to_done(100, 0);
        chk("stop_frame_count", 64'(frame_count), 64'd2);
        tick();
        tick();
        chk("stop_done_once", 64'(n_done - d0), 64'd1);
        chk("stop_idle", 64'({busy, vif.tvalid}), 64'd0);

        // start and stop together: exactly one frame
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        run_to_done(100, 0);
        chk("startstop_frame_count", 64'(frame_count), 64'd1);

        // clock enable low freezes everything
        mode = 3; num_frames = 1;
        do_start();
        wait_idx(5);
        held = vif.tdata;
        aclken = 0;
        repeat (4) begin
            tick();
            chk("clken_tdata_frozen", vif.tdata, held);
            chk("clken_tvalid_frozen", 64'(vif.tvalid), 64'd1);
        end
        aclken = 1;
        run_to_done(100, 0);
        chk("clken_frame_count", 64'(frame_count), 64'd1);

        // asynchronous reset mid-line, then a clean restart
        mode = 0; num_frames = 0;
        do_start();
        wait_idx(5);
        #2 aresetn = 0;
        #1;
        chk("arst_tvalid", 64'(vif.tvalid), 64'd0);
        chk("arst_tdata", vif.tdata, 64'd0);
        chk("arst_tuser_tlast", 64'({vif.tuser, vif.tlast}), 64'd0);
        chk("arst_busy_done", 64'({busy, done}), 64'd0);
        chk("arst_frame_count", 64'(frame_count), 64'd0);
        pend = 0;
        tick();
        tick();
        aresetn = 1;
        tick();
        num_frames = 1;
        do_start();
        chk("restart_tvalid", 64'(vif.tvalid), 64'd1);
        chk("restart_tuser", 64'(vif.tuser), 64'd1);
        run_to_done(100, 0);
        chk("restart_frame_count", 64'(frame_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
